// File: rtl/one_bit_processor.sv
// Serial-programmable 1-bit processor: programs are shifted in MSB-first on inReg[0] while en=1,
// then one instruction executes per clock from the 16-word memory while en=0.
module one_bit_processor #(
    parameter int INSTRUCTION_LENGTH = 13,
    parameter int INSTRUCTION_MEM    = 16,
    parameter int IN_REGS            = 2,
    parameter int OUT_REGS           = 7,
    parameter int INTERNAL_REGS      = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [IN_REGS-1:0]  inReg,
    output logic [OUT_REGS-1:0] outReg
);
    localparam int         WR_REGS  = OUT_REGS + INTERNAL_REGS;
    localparam int         ALL_REGS = IN_REGS + WR_REGS;
    localparam logic [3:0] LAST_BIT = 4'(INSTRUCTION_LENGTH - 1);
    localparam logic [3:0] FIRST_WR = 4'(IN_REGS);

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_MOV = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SET = 4'd5,
        OP_BRA = 4'd6,
        OP_JMP = 4'd7
    } opcode_t;

    logic [3:0]                    prog_counter;
    logic [INTERNAL_REGS-1:0]      internal_regs;
    logic [INSTRUCTION_LENGTH-1:0] instructions [INSTRUCTION_MEM];
    logic [3:0]                    load_ptr;
    logic [3:0]                    bit_cnt;
    // Only the last 12 bits are ever needed; the 13th arrives straight from inReg[0].
    logic [INSTRUCTION_LENGTH-2:0] load_shift;

    logic [INSTRUCTION_LENGTH-1:0] cur_instr;
    opcode_t                       op;
    logic [3:0]                    dst_addr;
    logic [3:0]                    src_addr;
    logic                          n_bit;
    logic [ALL_REGS-1:0]           reg_space;
    logic                          a_val;
    logic                          b_val;
    logic                          wr_en;
    logic                          wr_val;
    logic [WR_REGS-1:0]            next_wr;
    logic [3:0]                    next_pc;

    always_comb begin
        cur_instr = instructions[prog_counter];
        op        = opcode_t'(cur_instr[12:9]);
        dst_addr  = cur_instr[8:5];
        src_addr  = cur_instr[4:1];
        n_bit     = cur_instr[0];
        // Address map: 0-1 inputs, 2-8 outputs, 9-15 internal scratch bits.
        reg_space = {internal_regs, outReg, inReg};
        a_val     = reg_space[dst_addr];
        b_val     = reg_space[src_addr] ^ n_bit;
        wr_en     = 1'b0;
        wr_val    = 1'b0;
        next_pc   = prog_counter + 4'd1;
        case (op)
            OP_MOV: begin wr_en = 1'b1; wr_val = b_val;         end
            OP_AND: begin wr_en = 1'b1; wr_val = a_val & b_val; end
            OP_OR:  begin wr_en = 1'b1; wr_val = a_val | b_val; end
            OP_XOR: begin wr_en = 1'b1; wr_val = a_val ^ b_val; end
            OP_SET: begin wr_en = 1'b1; wr_val = n_bit;         end
            OP_BRA: if (b_val) next_pc = dst_addr;
            OP_JMP: next_pc = dst_addr;
            default: ;
        endcase
        next_wr = {internal_regs, outReg};
        if (wr_en && (dst_addr >= FIRST_WR)) begin
            next_wr[dst_addr - FIRST_WR] = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prog_counter  <= '0;
            internal_regs <= '0;
            outReg        <= '0;
            load_ptr      <= '0;
            bit_cnt       <= '0;
            load_shift    <= '0;
            for (int i = 0; i < INSTRUCTION_MEM; i++) begin
                instructions[i] <= '0;
            end
        end else if (en) begin
            load_shift <= {load_shift[INSTRUCTION_LENGTH-3:0], inReg[0]};
            if (bit_cnt == LAST_BIT) begin
                instructions[load_ptr] <= {load_shift, inReg[0]};
                bit_cnt                <= '0;
                load_ptr               <= load_ptr + 4'd1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else begin
            bit_cnt       <= '0;
            load_shift    <= '0;
            prog_counter  <= next_pc;
            outReg        <= next_wr[OUT_REGS-1:0];
            internal_regs <= next_wr[WR_REGS-1:OUT_REGS];
        end
    end

endmodule

// File: tb/tb_one_bit_processor.sv
// Scoreboard bench for one_bit_processor: stimulus queues expected values,
// a negedge monitor pops and compares them against the design state.
module tb_one_bit_processor;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [1:0] inReg = 2'b00;
    logic [6:0] outReg;

    one_bit_processor dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .inReg  (inReg),
        .outReg (outReg)
    );

    always #5 clk = ~clk;

    localparam int K_OUT = 0;
    localparam int K_PC  = 1;
    localparam int K_INT = 2;
    localparam int K_MEM = 3;
    localparam int K_PTR = 4;
    localparam int K_CNT = 5;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [12:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   n_compared = 0;
    int   n_mismatched = 0;

    always @(negedge clk) begin
        chk_t        c;
        logic [12:0] act;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            case (c.kind)
                K_OUT:   act = 13'(outReg);
                K_PC:    act = 13'(dut.prog_counter);
                K_INT:   act = 13'(dut.internal_regs);
                K_MEM:   act = dut.instructions[c.idx[3:0]];
                K_PTR:   act = 13'(dut.load_ptr);
                default: act = 13'(dut.bit_cnt);
            endcase
            n_compared++;
            if (act !== c.exp) begin
                n_mismatched++;
                $display("FAIL %s: got %b expected %b", c.name, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input int kind, input int idx, input logic [12:0] e);
        chk_t c;
        c.name = nm;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = e;
        exp_q.push_back(c);
    endtask

    function automatic logic [12:0] ins(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic n);
        return {op, a, b, n};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [12:0] w);
        en = 1'b1;
        for (int i = 12; i >= 0; i--) begin
            inReg = {inReg[1], w[i]};
            tick();
        end
    endtask

    // One pass of the shift program: 16 instructions, IN0 sampled by slot 7.
    task automatic run_pass(input logic in0);
        en    = 1'b0;
        inReg = {1'b0, in0};
        repeat (16) tick();
    endtask

    // SET INT0<-init; <op> INT0,IN0,n; MOV OUT0<-INT0; JMP 3 (spin).
    task automatic run_alu(input string nm, input logic [3:0] op, input logic init,
                           input logic n, input logic in0, input logic exp);
        do_reset();
        load_word(ins(4'd5, 4'd9, 4'd0, init));
        load_word(ins(op, 4'd9, 4'd0, n));
        load_word(ins(4'd1, 4'd2, 4'd9, 1'b0));
        load_word(ins(4'd7, 4'd3, 4'd0, 1'b0));
        en    = 1'b0;
        inReg = {1'b0, in0};
        repeat (8) tick();
        push({nm, "_out"}, K_OUT, 0, 13'(exp));
        push({nm, "_int"}, K_INT, 0, 13'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] shift_exp [11];
        logic       shift_in  [11];
        shift_in  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        shift_exp = '{7'b0000000, 7'b0000001, 7'b0000010, 7'b0000101, 7'b0001011, 7'b0010111,
                      7'b0101110, 7'b1011101, 7'b0111011, 7'b1110110, 7'b1101101};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        push("rst_out", K_OUT, 0, 13'd0);
        push("rst_pc",  K_PC,  0, 13'd0);
        push("rst_int", K_INT, 0, 13'd0);
        push("rst_mem0", K_MEM, 0, 13'd0);

        // Serial load and slot wrap
        load_word(13'h1FFF);
        push("load_ones", K_MEM, 0, 13'h1FFF);
        load_word(13'h0000);
        push("load_zero", K_MEM, 1, 13'h0000);
        push("load_keep0", K_MEM, 0, 13'h1FFF);
        load_word(13'h1555);
        load_word(13'h0AAA);
        push("load_alt2", K_MEM, 2, 13'h1555);
        push("load_alt3", K_MEM, 3, 13'h0AAA);
        push("load_pc_hold", K_PC, 0, 13'd0);
        for (int i = 4; i < 16; i++) load_word(13'h0100 + 13'(i));
        load_word(13'h0123);
        push("wrap_slot0", K_MEM, 0, 13'h0123);
        push("wrap_slot15", K_MEM, 15, 13'h010F);
        push("wrap_ptr", K_PTR, 0, 13'd1);

        // Partial word discarded on leaving load mode
        do_reset();
        en    = 1'b1;
        inReg = 2'b01;
        repeat (5) tick();
        en = 1'b0;
        repeat (16) tick();
        push("partial_cnt", K_CNT, 0, 13'd0);
        push("partial_pc",  K_PC,  0, 13'd0);
        push("partial_ptr", K_PTR, 0, 13'd0);

        // Shift-register program
        load_word(ins(4'd6, 4'd0, 4'd1, 1'b0));
        for (int k = 6; k >= 1; k--) load_word(ins(4'd1, 4'(k + 2), 4'(k + 1), 1'b0));
        load_word(ins(4'd1, 4'd2, 4'd0, 1'b0));
        for (int k = 8; k < 16; k++) load_word(13'h0000);
        push("prog_slot7", K_MEM, 7, 13'h0240);
        en    = 1'b0;
        inReg = 2'b11;
        repeat (20) tick();
        push("hold_out", K_OUT, 0, 13'd0);
        push("hold_pc",  K_PC,  0, 13'd0);

        for (int p = 0; p < 6; p++) begin
            run_pass(shift_in[p]);
            push($sformatf("shift_%0d", p), K_OUT, 0, 13'(shift_exp[p]));
        end

        inReg = 2'b10;
        for (int c = 0; c < 640; c++) begin
            inReg[0] = ~inReg[0];
            tick();
        end
        push("pause_out", K_OUT, 0, 13'(7'b0010111));
        push("pause_pc",  K_PC,  0, 13'd0);

        for (int p = 6; p < 11; p++) begin
            run_pass(shift_in[p]);
            push($sformatf("shift_%0d", p), K_OUT, 0, 13'(shift_exp[p]));
        end
        repeat (7) run_pass(1'b1);
        push("fill_ones", K_OUT, 0, 13'(7'b1111111));

        // Reset mid-run
        inReg = 2'b00;
        repeat (5) tick();
        push("midrun_pc", K_PC, 0, 13'd5);
        reset = 1'b1;
        tick();
        push("midrst_out", K_OUT, 0, 13'd0);
        push("midrst_pc",  K_PC,  0, 13'd0);
        push("midrst_mem", K_MEM, 1, 13'd0);
        push("midrst_ptr", K_PTR, 0, 13'd0);
        reset = 1'b0;

        // ALU / SET / undefined opcodes
        run_alu("mov_n0",  4'd1,  1'b0, 1'b0, 1'b1, 1'b1);
        run_alu("mov_n1",  4'd1,  1'b0, 1'b1, 1'b1, 1'b0);
        run_alu("and_n0",  4'd2,  1'b1, 1'b0, 1'b1, 1'b1);
        run_alu("and_n1",  4'd2,  1'b1, 1'b1, 1'b1, 1'b0);
        run_alu("or_n0",   4'd3,  1'b0, 1'b0, 1'b0, 1'b0);
        run_alu("or_n1",   4'd3,  1'b0, 1'b1, 1'b0, 1'b1);
        run_alu("xor_n0",  4'd4,  1'b1, 1'b0, 1'b1, 1'b0);
        run_alu("xor_n1",  4'd4,  1'b1, 1'b1, 1'b1, 1'b1);
        run_alu("xor_0_1", 4'd4,  1'b0, 1'b0, 1'b1, 1'b1);
        run_alu("set_1",   4'd5,  1'b0, 1'b1, 1'b0, 1'b1);
        run_alu("set_0",   4'd5,  1'b1, 1'b0, 1'b1, 1'b0);
        run_alu("op8_nop", 4'd8,  1'b1, 1'b0, 1'b0, 1'b1);
        run_alu("op15_nop", 4'd15, 1'b0, 1'b0, 1'b1, 1'b0);

        // Writes to the input addresses are dropped
        do_reset();
        load_word(ins(4'd5, 4'd0, 4'd0, 1'b1));
        load_word(ins(4'd5, 4'd1, 4'd0, 1'b1));
        load_word(ins(4'd1, 4'd2, 4'd0, 1'b0));
        load_word(ins(4'd1, 4'd3, 4'd1, 1'b0));
        load_word(ins(4'd7, 4'd4, 4'd0, 1'b0));
        en    = 1'b0;
        inReg = 2'b00;
        repeat (8) tick();
        push("wr_in_ignored", K_OUT, 0, 13'd0);

        // JMP
        do_reset();
        load_word(ins(4'd7, 4'd5, 4'd0, 1'b0));
        en = 1'b0;
        tick();
        push("jmp_pc", K_PC, 0, 13'd5);
        tick();
        push("jmp_pc_next", K_PC, 0, 13'd6);

        repeat (3) tick();
        if (exp_q.size() > 0) begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            n_mismatched += exp_q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
